fc_layer_sequencer: RTL and testbench
=====================================

FC_LAYER_SEQUENCER -- requirements
Module: fc_layer_sequencer

Interface
REQ-001 The block SHALL have parameter FEATURE_WORDS, default 64, meaning 32-bit feature beats per layer.
REQ-002 The block SHALL have parameter BIAS_WORDS, default 16, meaning 32-bit bias beats per layer.
REQ-003 The block SHALL have parameter WEIGHT_SETS, default 512, meaning weight sets (8 beats each) per layer.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 65535, meaning maximum cycles allowed per phase.
REQ-005 The block SHALL have port clk, input, 1 bit, sole clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-007 The block SHALL have port layer_start, input, 1 bit, a one-cycle request to run one layer.
REQ-008 The block SHALL have port fc_start, output, 1 bit, start level to the fc engine.
REQ-009 The block SHALL have port command, output, 3 bits, phase command to the engine: 000 idle, 001 feature, 010 bias, 100 weight, 101 compute.
REQ-010 The block SHALL have port receive_size, output, 21 bits, beat count expected in the current load phase.
REQ-011 The block SHALL have ports f_writedone, b_writedone, w_writedone, cal_done, fc_done, inputs, 1 bit each, status pulses/levels from the engine.
REQ-012 The block SHALL have port engine_max_index, input, 32 bits, the engine's argmax output.
REQ-013 The block SHALL have ports s_beat_valid and s_beat_ready, inputs, 1 bit each, a monitor tap on the engine's input stream.
REQ-014 The block SHALL have outputs busy (1), layer_done (1), error (1), err_code (2), result_index (32) and weight_sets_done (16).

Function
REQ-015 States SHALL be IDLE, START, FEAT, BIAS, WGT, CALC, SEND, DONE, ERR.
REQ-016 IDLE: on layer_start=1, go to START; all other inputs are ignored.
REQ-017 START: fc_start=1 and command=001 for exactly one cycle, then go to FEAT.
- In START, FEAT, BIAS and WGT, fc_start SHALL stay 1 until WGT exits.
REQ-018 FEAT: command=001, receive_size=FEATURE_WORDS.
- On f_writedone=1, go to BIAS, with command=010 from the next cycle.
REQ-019 BIAS: command=010, receive_size=BIAS_WORDS.
- On b_writedone=1, go to WGT, with command=100 from the next cycle.
REQ-020 WGT: command=100, receive_size=8.
- Each cycle with w_writedone=1 increments weight_sets_done by 1.
- When the increment reaches WEIGHT_SETS, go to CALC with command=101.
- w_writedone held high for consecutive cycles SHALL count once per rising edge only.
REQ-021 CALC: command=101; on cal_done=1 or fc_done=1, go to SEND.
REQ-022 SEND: on fc_done=1, latch result_index from engine_max_index and go to DONE.
REQ-023 DONE: layer_done=1 for exactly one cycle, command=000, fc_start=0, then go to IDLE.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 Beat counter:
- Counts cycles with s_beat_valid and s_beat_ready both 1 in FEAT and BIAS.
- Clears on each phase entry.
- If the phase's done pulse arrives with count != receive_size, go to ERR with err_code=01.
REQ-026 Watchdog:
- A 16-bit phase timer clears on every state change and increments otherwise.
- Reaching TIMEOUT_CYCLES in FEAT..SEND SHALL go to ERR with err_code=10.
REQ-027 A done pulse for a phase other than the current one (for example b_writedone in FEAT) SHALL go to ERR with err_code=11.
- An overflow or mismatch error (REQ-025 or REQ-026) in the same cycle takes priority over err_code=11.
REQ-028 ERR: error=1, command=000, fc_start=0.
- Stays in ERR until layer_start=1, which clears error and err_code and goes to START.
REQ-029 layer_start while busy SHALL be ignored in every state except ERR.
REQ-030 weight_sets_done SHALL clear on entry to START and hold its value through DONE, IDLE and ERR.
REQ-031 result_index SHALL change only in SEND and hold its value otherwise.

Reset
REQ-032 rst=1 SHALL force, asynchronously:
- state=IDLE;
- fc_start=0, command=000, receive_size=0;
- busy=0, layer_done=0, error=0, err_code=00;
- result_index=0, weight_sets_done=0;
- beat and phase timers=0.
REQ-033 Reset asserted mid-layer SHALL abort with no layer_done pulse; the first post-reset layer_start SHALL run normally.

Verification
REQ-034 Nominal run: layer_start; 64 beats, then f_writedone; 16 beats, then b_writedone; 512 w_writedone pulses; cal_done; fc_done with engine_max_index=7 -> command sequence 001,010,100,101,000; result_index=7; weight_sets_done=512; one layer_done pulse.
REQ-035 63 beats, then f_writedone -> ERR, err_code=01, error=1, fc_start=0.
REQ-036 In WGT, no w_writedone for TIMEOUT_CYCLES (set 100) -> ERR, err_code=10, on cycle 100 after WGT entry.
REQ-037 b_writedone pulse during FEAT -> ERR, err_code=11; a following layer_start -> START and error=0.
REQ-038 w_writedone held high for 5 cycles -> weight_sets_done increments by 1 only.
REQ-039 rst pulse during WGT after 200 sets -> all outputs at reset values immediately; a subsequent full run completes with weight_sets_done=512.

Source files
------------

// File: rtl/fc_layer_sequencer.sv
// Layer sequencer for the fully-connected engine: walks feature, bias and weight loads,
// then compute and result collection, with beat-count, watchdog and protocol error detection.
module fc_layer_sequencer #(
    parameter int unsigned FEATURE_WORDS  = 64,
    parameter int unsigned BIAS_WORDS     = 16,
    parameter int unsigned WEIGHT_SETS    = 512,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        layer_start,
    output logic        fc_start,
    output logic [2:0]  command,
    output logic [20:0] receive_size,
    input  logic        f_writedone,
    input  logic        b_writedone,
    input  logic        w_writedone,
    input  logic        cal_done,
    input  logic        fc_done,
    input  logic [31:0] engine_max_index,
    input  logic        s_beat_valid,
    input  logic        s_beat_ready,
    output logic        busy,
    output logic        layer_done,
    output logic        error,
    output logic [1:0]  err_code,
    output logic [31:0] result_index,
    output logic [15:0] weight_sets_done
);

    typedef enum logic [3:0] {
        StIdle, StStart, StFeat, StBias, StWgt, StCalc, StSend, StDone, StErr
    } state_e;

    localparam logic [20:0] FeatSize    = 21'(FEATURE_WORDS);
    localparam logic [20:0] BiasSize    = 21'(BIAS_WORDS);
    localparam logic [15:0] WeightSets  = 16'(WEIGHT_SETS);
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [20:0] beat_q, beat_d;
    logic [15:0] timer_q, timer_d;
    logic [15:0] sets_q, sets_d;
    logic [31:0] result_q, result_d;
    logic [1:0]  err_code_q, err_code_d;
    logic        w_prev_q;

    logic       w_rise;
    logic       in_phase;
    logic       timeout;
    logic       mismatch;
    logic       foreign;
    logic [4:0] pulses;
    logic [4:0] allowed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            beat_q     <= '0;
            timer_q    <= '0;
            sets_q     <= '0;
            result_q   <= '0;
            err_code_q <= '0;
            w_prev_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            timer_q    <= timer_d;
            sets_q     <= sets_d;
            result_q   <= result_d;
            err_code_q <= err_code_d;
            w_prev_q   <= w_writedone;
        end
    end

    // Weight completion is edge-based so a held w_writedone counts once.
    assign w_rise   = w_writedone & ~w_prev_q;
    assign pulses   = {f_writedone, b_writedone, w_rise, cal_done, fc_done};
    assign in_phase = (state_q == StFeat) || (state_q == StBias) || (state_q == StWgt) ||
                      (state_q == StCalc) || (state_q == StSend);

    always_comb begin
        allowed = 5'b11111;
        unique case (state_q)
            StFeat:         allowed = 5'b10000;
            StBias:         allowed = 5'b01000;
            StWgt:          allowed = 5'b00100;
            StCalc, StSend: allowed = 5'b00011;
            default:        allowed = 5'b11111;
        endcase
    end

    assign timeout  = in_phase && (timer_q == TimeoutLast);
    assign mismatch = ((state_q == StFeat) && f_writedone && (beat_q != FeatSize)) ||
                      ((state_q == StBias) && b_writedone && (beat_q != BiasSize));
    assign foreign  = in_phase && (|(pulses & ~allowed));

    always_comb begin
        state_d    = state_q;
        sets_d     = sets_q;
        result_d   = result_q;
        err_code_d = err_code_q;
        beat_d     = beat_q;
        timer_d    = timer_q + 16'd1;

        unique case (state_q)
            StIdle:  if (layer_start) state_d = StStart;
            StStart: state_d = StFeat;
            StFeat:  if (f_writedone) state_d = StBias;
            StBias:  if (b_writedone) state_d = StWgt;
            StWgt: begin
                if (w_rise) begin
                    sets_d = sets_q + 16'd1;
                    if (sets_q + 16'd1 == WeightSets) state_d = StCalc;
                end
            end
            StCalc:  if (cal_done || fc_done) state_d = StSend;
            StSend:  if (fc_done) state_d = StDone;
            StDone:  state_d = StIdle;
            StErr: begin
                if (layer_start) begin
                    state_d    = StStart;
                    err_code_d = 2'b00;
                end
            end
            default: state_d = StIdle;
        endcase

        // Watchdog beats count mismatch, which beats an out-of-phase done pulse.
        if (timeout) begin
            state_d    = StErr;
            err_code_d = 2'b10;
        end else if (mismatch) begin
            state_d    = StErr;
            err_code_d = 2'b01;
        end else if (foreign) begin
            state_d    = StErr;
            err_code_d = 2'b11;
        end

        if ((state_q == StSend) && (state_d == StDone)) result_d = engine_max_index;
        if (state_d == StStart) sets_d = '0;

        if (state_d != state_q) begin
            beat_d  = '0;
            timer_d = '0;
        end else if (((state_q == StFeat) || (state_q == StBias)) &&
                     s_beat_valid && s_beat_ready) begin
            beat_d = beat_q + 21'd1;
        end
    end

    always_comb begin
        fc_start     = 1'b0;
        command      = 3'b000;
        receive_size = '0;
        unique case (state_q)
            StStart, StFeat: begin
                fc_start     = 1'b1;
                command      = 3'b001;
                receive_size = FeatSize;
            end
            StBias: begin
                fc_start     = 1'b1;
                command      = 3'b010;
                receive_size = BiasSize;
            end
            StWgt: begin
                fc_start     = 1'b1;
                command      = 3'b100;
                receive_size = 21'd8;
            end
            StCalc, StSend: command = 3'b101;
            default: ;
        endcase
    end

    assign busy             = (state_q != StIdle);
    assign layer_done       = (state_q == StDone);
    assign error            = (state_q == StErr);
    assign err_code         = err_code_q;
    assign result_index     = result_q;
    assign weight_sets_done = sets_q;

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Randomized bench for fc_layer_sequencer: a phase-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_fc_layer_sequencer;

    localparam int FW = 64;
    localparam int BW = 16;
    localparam int WS = 512;
    localparam int TO = 3000;

    localparam int PI = 0, PS = 1, PF = 2, PB = 3, PW = 4, PC = 5, PN = 6, PD = 7, PE = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        layer_start = 1'b0;
    logic        f_wd = 1'b0, b_wd = 1'b0, w_wd = 1'b0, cal_done = 1'b0, fc_done = 1'b0;
    logic [31:0] emi = '0;
    logic        s_v = 1'b0, s_r = 1'b0;

    logic        fc_start, busy, layer_done, error;
    logic [2:0]  command;
    logic [20:0] receive_size;
    logic [1:0]  err_code;
    logic [31:0] result_index;
    logic [15:0] weight_sets_done;

    always #5 clk = ~clk;

    fc_layer_sequencer #(
        .FEATURE_WORDS (FW),
        .BIAS_WORDS    (BW),
        .WEIGHT_SETS   (WS),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .layer_start     (layer_start),
        .fc_start        (fc_start),
        .command         (command),
        .receive_size    (receive_size),
        .f_writedone     (f_wd),
        .b_writedone     (b_wd),
        .w_writedone     (w_wd),
        .cal_done        (cal_done),
        .fc_done         (fc_done),
        .engine_max_index(emi),
        .s_beat_valid    (s_v),
        .s_beat_ready    (s_r),
        .busy            (busy),
        .layer_done      (layer_done),
        .error           (error),
        .err_code        (err_code),
        .result_index    (result_index),
        .weight_sets_done(weight_sets_done)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phases advance in order FEAT..DONE on each phase's own done event.
    int          m_ph = PI, m_nxt = PI, m_beats = 0, m_timer = 0, m_sets = 0;
    logic [31:0] m_res = '0;
    logic [1:0]  m_ec = '0;
    bit          m_wprev = 1'b0, m_wrise = 1'b0;
    logic [4:0]  m_evt = '0;

    function automatic logic [4:0] own_mask(input int ph);
        case (ph)
            PF:      return 5'b10000;
            PB:      return 5'b01000;
            PW:      return 5'b00100;
            default: return 5'b00011;
        endcase
    endfunction

    function automatic bit phase_done(input int ph, input int sets, input bit wr);
        case (ph)
            PF:      return f_wd;
            PB:      return b_wd;
            PW:      return wr && (sets == WS);
            PC:      return cal_done || fc_done;
            default: return fc_done;
        endcase
    endfunction

    always begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_ph = PI; m_beats = 0; m_timer = 0; m_sets = 0;
            m_res = '0; m_ec = '0; m_wprev = 1'b0;
        end else begin
            m_wrise = w_wd && !m_wprev;
            m_evt   = {f_wd, b_wd, m_wrise, cal_done, fc_done};
            m_nxt   = m_ph;
            if (m_ph == PI) begin
                if (layer_start) m_nxt = PS;
            end else if (m_ph == PS) begin
                m_nxt = PF;
            end else if (m_ph == PD) begin
                m_nxt = PI;
            end else if (m_ph == PE) begin
                if (layer_start) begin m_nxt = PS; m_ec = 2'b00; end
            end else begin
                if (m_ph == PW && m_wrise) m_sets++;
                if (m_timer + 1 == TO) begin
                    m_nxt = PE; m_ec = 2'b10;
                end else if ((m_ph == PF && f_wd && m_beats != FW) ||
                             (m_ph == PB && b_wd && m_beats != BW)) begin
                    m_nxt = PE; m_ec = 2'b01;
                end else if ((m_evt & ~own_mask(m_ph)) != 5'b0) begin
                    m_nxt = PE; m_ec = 2'b11;
                end else if (phase_done(m_ph, m_sets, m_wrise)) begin
                    if (m_ph == PN) m_res = emi;
                    m_nxt = m_ph + 1;
                end
            end
            if (m_nxt != m_ph) begin
                m_timer = 0; m_beats = 0;
            end else begin
                m_timer = (m_timer + 1) % 65536;
                if ((m_ph == PF || m_ph == PB) && s_v && s_r) m_beats++;
            end
            if (m_nxt == PS) m_sets = 0;
            m_ph    = m_nxt;
            m_wprev = w_wd;
        end
    end

    function automatic int exp_cmd(input int ph);
        case (ph)
            PS, PF:  return 1;
            PB:      return 2;
            PW:      return 4;
            PC, PN:  return 5;
            default: return 0;
        endcase
    endfunction

    function automatic int exp_rs(input int ph);
        case (ph)
            PS, PF:  return FW;
            PB:      return BW;
            PW:      return 8;
            default: return 0;
        endcase
    endfunction

    // Per-cycle comparison and event monitors.
    logic [2:0] last_cmd = 3'b000;
    logic [2:0] cmd_log[$];
    int         ld_count = 0;

    always @(negedge clk) begin
        if (cmp_on) begin
            check("command", 32'(command), 32'(exp_cmd(m_ph)));
            check("fc_start", 32'(fc_start), 32'(m_ph >= PS && m_ph <= PW));
            check("receive_size", 32'(receive_size), 32'(exp_rs(m_ph)));
            check("busy", 32'(busy), 32'(m_ph != PI));
            check("layer_done", 32'(layer_done), 32'(m_ph == PD));
            check("error", 32'(error), 32'(m_ph == PE));
            check("err_code", 32'(err_code), 32'(m_ec));
            check("result_index", result_index, m_res);
            check("weight_sets_done", 32'(weight_sets_done), 32'(m_sets));
        end
        if (command != last_cmd) begin
            cmd_log.push_back(command);
            last_cmd = command;
        end
        if (layer_done) ld_count++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_layer();
        layer_start = 1'b1;
        tick();
        layer_start = 1'b0;
        tick();
    endtask

    task automatic feed_beats(input int n);
        int cnt = 0;
        while (cnt < n) begin
            s_v = ($urandom % 4) != 0;
            s_r = ($urandom % 4) != 0;
            if (s_v && s_r) cnt++;
            tick();
        end
        s_v = 1'b0;
        s_r = 1'b0;
    endtask

    task automatic pulse_f();
        f_wd = 1'b1; tick(); f_wd = 1'b0;
    endtask

    task automatic pulse_b();
        b_wd = 1'b1; tick(); b_wd = 1'b0;
    endtask

    task automatic feed_w(input int n);
        for (int i = 0; i < n; i++) begin
            w_wd = 1'b1;
            repeat (1 + $urandom % 2) tick();
            w_wd = 1'b0;
            repeat (1 + $urandom % 2) begin
                layer_start = ($urandom % 16) == 0;
                tick();
                layer_start = 1'b0;
            end
        end
    endtask

    task automatic finish_layer(input logic [31:0] idx);
        emi = idx;
        if ($urandom % 2 == 1) begin
            cal_done = 1'b1; tick(); cal_done = 1'b0;
            repeat ($urandom % 3) tick();
            fc_done = 1'b1; tick(); fc_done = 1'b0;
        end else begin
            fc_done = 1'b1; tick(); tick(); fc_done = 1'b0;
        end
        tick();
        emi = $urandom;
        tick();
    endtask

    task automatic full_layer(input logic [31:0] idx);
        start_layer();
        feed_beats(FW); pulse_f();
        feed_beats(BW); pulse_b();
        feed_w(WS);
        finish_layer(idx);
    endtask

    int exp_seq[5];
    int ls0, ld0, n;
    logic [31:0] idx;

    initial begin
        exp_seq[0] = 1; exp_seq[1] = 2; exp_seq[2] = 4; exp_seq[3] = 5; exp_seq[4] = 0;
        repeat (3) tick();
        cmp_on = 1'b1;
        check("rst_busy", 32'(busy), 0);
        check("rst_command", 32'(command), 0);
        check("rst_receive_size", 32'(receive_size), 0);
        check("rst_sets", 32'(weight_sets_done), 0);
        rst = 1'b0;
        tick();

        // Nominal layer
        ls0 = cmd_log.size();
        ld0 = ld_count;
        full_layer(32'd7);
        check("nom_result", result_index, 7);
        check("nom_sets", 32'(weight_sets_done), 512);
        check("nom_layer_done", 32'(ld_count - ld0), 1);
        check("nom_cmd_count", 32'(cmd_log.size() - ls0), 5);
        for (int i = 0; i < 5; i++)
            if (ls0 + i < cmd_log.size())
                check($sformatf("nom_cmd%0d", i), 32'(cmd_log[ls0 + i]), 32'(exp_seq[i]));

        // Stray status pulses in IDLE are ignored
        repeat (6) begin
            {f_wd, b_wd, cal_done, fc_done} = 4'($urandom);
            tick();
        end
        {f_wd, b_wd, cal_done, fc_done} = 4'b0;
        tick();
        check("idle_stray_busy", 32'(busy), 0);

        // Short feature load
        start_layer();
        feed_beats(FW - 1);
        pulse_f();
        check("mm_error", 32'(error), 1);
        check("mm_code", 32'(err_code), 1);
        check("mm_fc_start", 32'(fc_start), 0);

        // Restart from ERR, then an out-of-phase bias done during FEAT
        layer_start = 1'b1; tick(); layer_start = 1'b0;
        check("restart_error", 32'(error), 0);
        check("restart_cmd", 32'(command), 1);
        tick();
        feed_beats(10);
        pulse_b();
        check("foreign_error", 32'(error), 1);
        check("foreign_code", 32'(err_code), 3);

        // Watchdog in WGT
        start_layer();
        feed_beats(FW); pulse_f();
        feed_beats(BW); pulse_b();
        n = 0;
        while (!error && n < TO + 50) begin
            tick();
            n++;
        end
        check("to_cycles", 32'(n), TO);
        check("to_code", 32'(err_code), 2);

        // Held w_writedone counts once; reset in the middle of WGT
        start_layer();
        feed_beats(FW); pulse_f();
        feed_beats(BW); pulse_b();
        w_wd = 1'b1; repeat (5) tick(); w_wd = 1'b0; tick();
        check("hold_sets", 32'(weight_sets_done), 1);
        feed_w(199);
        check("pre_rst_sets", 32'(weight_sets_done), 200);
        ld0 = ld_count;
        #3 rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 0);
        check("arst_command", 32'(command), 0);
        check("arst_fc_start", 32'(fc_start), 0);
        check("arst_sets", 32'(weight_sets_done), 0);
        check("arst_result", result_index, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("arst_no_done", 32'(ld_count - ld0), 0);
        full_layer(32'd12345);
        check("post_rst_sets", 32'(weight_sets_done), 512);
        check("post_rst_result", result_index, 12345);

        // Random mix of clean layers and injected faults
        repeat (6) begin
            idx = $urandom;
            case ($urandom % 4)
                0, 1: begin
                    full_layer(idx);
                    check("rand_result", result_index, idx);
                end
                2: begin
                    start_layer();
                    feed_beats(FW); pulse_f();
                    feed_beats(BW - 1); pulse_b();
                    check("rand_mm_code", 32'(err_code), 1);
                end
                default: begin
                    start_layer();
                    feed_beats(FW); pulse_f();
                    feed_beats(BW); pulse_b();
                    feed_w(1 + $urandom % 50);
                    cal_done = 1'b1; tick(); cal_done = 1'b0;
                    check("rand_foreign_code", 32'(err_code), 3);
                end
            endcase
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

endmodule
